// File: rtl/fib_pkg.sv
// Shared types for the Fibonacci pair serializer: one term and a buffered (earlier, later) pair.
package fib_pkg;

  localparam int unsigned FIB_W = 16;

  typedef logic [FIB_W-1:0] fib_t;

  typedef struct packed {
    fib_t num;
    fib_t num2;
  } fib_pair_t;

endpackage

// File: rtl/fib_pair_fifo.sv
// Synchronous DEPTH-entry FIFO of Fibonacci term pairs with occupancy level.
module fib_pair_fifo
  import fib_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  fib_pair_t                din,
  input  logic                     pop,
  output fib_pair_t                head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  fib_pair_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     level_q, level_d;
  logic            push_en, pop_en;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign head    = mem[rd_ptr_q];
  assign level   = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    // DEPTH is a power of two, so pointer overflow wraps modulo DEPTH.
    if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_en, pop_en})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/fib_pair_serializer.sv
// Serializes buffered Fibonacci pairs into one term per cycle with index and wrap detection.
// Define FIB_PAIR_SERIALIZER_CHECK_EN to add the sticky Fibonacci-rule check on seq_err.
module fib_pair_serializer
  import fib_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDX_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   up_valid,
  output logic                   up_ready,
  input  logic [FIB_W-1:0]       up_num,
  input  logic [FIB_W-1:0]       up_num2,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [FIB_W-1:0]       out_num,
  output logic [IDX_W-1:0]       out_idx,
  output logic [$clog2(DEPTH):0] level,
  output logic                   wrap_err,
  output logic                   seq_err
);

  fib_pair_t        din_pair;
  fib_pair_t        head;
  logic             full, empty;
  logic             push, take;
  logic             half_q, half_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  fib_t             prev_q, prev_d;
  logic             have_prev_q, have_prev_d;
  logic             wrap_q, wrap_d;

  assign din_pair  = '{num: up_num, num2: up_num2};
  assign up_ready  = !full;
  assign push      = up_valid && up_ready;
  assign out_valid = !empty;
  assign take      = out_valid && out_ready;
  assign out_num   = out_valid ? (half_q ? head.num2 : head.num) : '0;
  assign out_idx   = idx_q;
  assign wrap_err  = wrap_q;

  // Entry is released only once its later term has been taken.
  fib_pair_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (din_pair),
    .pop   (take && half_q),
    .head  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_comb begin
    half_d      = half_q;
    idx_d       = idx_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    wrap_d      = wrap_q;
    if (take) begin
      half_d      = !half_q;
      prev_d      = out_num;
      have_prev_d = 1'b1;
      if (idx_q != '1) idx_d = idx_q + 1'b1;
      if (have_prev_q && (out_num < prev_q)) wrap_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      half_q      <= 1'b0;
      idx_q       <= '0;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      half_q      <= half_d;
      idx_q       <= idx_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      wrap_q      <= wrap_d;
    end
  end

`ifdef FIB_PAIR_SERIALIZER_CHECK_EN
  fib_t       prev2_q, prev2_d;
  fib_t       rule_sum;
  logic [1:0] seen_q, seen_d;
  logic       seq_q, seq_d;

  // Sum is truncated to 16 bits so wrapped Fibonacci terms still satisfy the rule.
  assign rule_sum = prev_q + prev2_q;
  assign seq_err  = seq_q;

  always_comb begin
    prev2_d = prev2_q;
    seen_d  = seen_q;
    seq_d   = seq_q;
    if (take) begin
      prev2_d = prev_q;
      if (seen_q != 2'd2) seen_d = seen_q + 1'b1;
      if ((seen_q == 2'd2) && (out_num != rule_sum)) seq_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev2_q <= '0;
      seen_q  <= '0;
      seq_q   <= 1'b0;
    end else begin
      prev2_q <= prev2_d;
      seen_q  <= seen_d;
      seq_q   <= seq_d;
    end
  end
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_fib_pair_serializer.sv
// Directed bench for fib_pair_serializer: ordering, backpressure, wrap flag, rule check, reset.
module tb_fib_pair_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        up_valid;
  logic        up_ready;
  logic [15:0] up_num;
  logic [15:0] up_num2;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_num;
  logic [15:0] out_idx;
  logic [2:0]  level;
  logic        wrap_err;
  logic        seq_err;

`ifdef FIB_PAIR_SERIALIZER_CHECK_EN
  localparam logic EXP_SEQ = 1'b1;
`else
  localparam logic EXP_SEQ = 1'b0;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int exp_idx = 0;

  fib_pair_serializer #(
    .DEPTH (4),
    .IDX_W (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .up_valid  (up_valid),
    .up_ready  (up_ready),
    .up_num    (up_num),
    .up_num2   (up_num2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_num   (out_num),
    .out_idx   (out_idx),
    .level     (level),
    .wrap_err  (wrap_err),
    .seq_err   (seq_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    up_valid  = 1'b0;
    out_ready = 1'b0;
    up_num    = '0;
    up_num2   = '0;
    tick();
    tick();
    rst     = 1'b1;
    exp_idx = 0;
  endtask

  // Checks the presented term, lets it be taken on the next edge (out_ready must be 1).
  task automatic expect_term(input string tag, input logic [15:0] v);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_num"}, out_num, v);
    chk({tag, "_idx"}, out_idx, exp_idx);
    tick();
    exp_idx++;
  endtask

  logic [15:0] sb[$];
  logic [15:0] exp_v;
  logic [15:0] held_num, held_idx;
  logic        stalled;
  int          k, sent, cycles;

  initial begin
    do_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_up_ready", up_ready, 1);
    chk("rst_out_num", out_num, 0);
    chk("rst_level", level, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_wrap", wrap_err, 0);
    chk("rst_seq", seq_err, 0);

    // Back-to-back pairs, consumer always ready.
    out_ready = 1'b1;
    up_valid = 1'b1; up_num = 16'd1; up_num2 = 16'd1;
    chk("t1_no_bypass", out_valid, 0);
    tick();
    up_num = 16'd2; up_num2 = 16'd3;
    expect_term("t1_a", 16'd1);
    up_num = 16'd5; up_num2 = 16'd8;
    expect_term("t1_b", 16'd1);
    up_valid = 1'b0;
    expect_term("t1_c", 16'd2);
    expect_term("t1_d", 16'd3);
    expect_term("t1_e", 16'd5);
    expect_term("t1_f", 16'd8);
    chk("t1_drained", out_valid, 0);
    chk("t1_wrap", wrap_err, 0);

    // Fill to capacity with the consumer stalled.
    out_ready = 1'b0;
    up_valid  = 1'b1;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      up_num  = 16'(10 + 2 * k);
      up_num2 = 16'(11 + 2 * k);
      if (up_ready) k++;
      tick();
    end
    chk("t2_accepted", k, 4);
    chk("t2_level_full", level, 4);
    chk("t2_up_ready_full", up_ready, 0);
    out_ready = 1'b1;
    chk("t2_ready_first_half", up_ready, 0);
    expect_term("t2_10", 16'd10);
    chk("t2_ready_second_half", up_ready, 0);
    expect_term("t2_11", 16'd11);
    chk("t2_ready_back", up_ready, 1);
    expect_term("t2_12", 16'd12);
    up_valid = 1'b0;
    for (int v = 13; v <= 19; v++) expect_term("t2_drain", 16'(v));
    chk("t2_drained", out_valid, 0);
    chk("t2_level_empty", level, 0);

    // 16-bit wrap of the Fibonacci sequence.
    do_reset();
    out_ready = 1'b1;
    up_valid = 1'b1; up_num = 16'd28657; up_num2 = 16'd46368;
    tick();
    up_num = 16'd9489; up_num2 = 16'd55857;
    expect_term("t3_a", 16'd28657);
    up_valid = 1'b0;
    expect_term("t3_b", 16'd46368);
    chk("t3_wrap_before", wrap_err, 0);
    expect_term("t3_c", 16'd9489);
    chk("t3_wrap_set", wrap_err, 1);
    expect_term("t3_d", 16'd55857);
    chk("t3_wrap_sticky", wrap_err, 1);
    chk("t3_seq", seq_err, 0);
    tick();
    chk("t3_wrap_held", wrap_err, 1);

    // Fibonacci-rule violation.
    do_reset();
    out_ready = 1'b1;
    up_valid = 1'b1; up_num = 16'd1; up_num2 = 16'd1;
    tick();
    up_num = 16'd2; up_num2 = 16'd4;
    expect_term("t4_a", 16'd1);
    up_valid = 1'b0;
    expect_term("t4_b", 16'd1);
    chk("t4_seq_pre", seq_err, 0);
    expect_term("t4_c", 16'd2);
    chk("t4_seq_ok", seq_err, 0);
    expect_term("t4_d", 16'd4);
    chk("t4_seq_after", seq_err, EXP_SEQ);

    // Reset mid-stream with three pairs stored and the head half-taken.
    do_reset();
    up_valid = 1'b1;
    for (int p = 0; p < 4; p++) begin
      case (p)
        0:       begin up_num = 16'd7;  up_num2 = 16'd3;  end
        1:       begin up_num = 16'd20; up_num2 = 16'd21; end
        2:       begin up_num = 16'd22; up_num2 = 16'd23; end
        default: begin up_num = 16'd24; up_num2 = 16'd25; end
      endcase
      tick();
    end
    up_valid  = 1'b0;
    out_ready = 1'b1;
    tick(); tick(); tick();
    out_ready = 1'b0;
    chk("t5_level", level, 3);
    chk("t5_half", out_num, 21);
    chk("t5_wrap", wrap_err, 1);
    chk("t5_seq", seq_err, EXP_SEQ);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_level", level, 0);
    chk("t5_rst_wrap", wrap_err, 0);
    chk("t5_rst_seq", seq_err, 0);
    chk("t5_rst_ready", up_ready, 1);
    chk("t5_rst_num", out_num, 0);
    exp_idx = 0;
    up_valid = 1'b1; up_num = 16'd1; up_num2 = 16'd1;
    tick();
    up_valid  = 1'b0;
    out_ready = 1'b1;
    expect_term("t5_a", 16'd1);
    expect_term("t5_b", 16'd1);
    chk("t5_drained", out_valid, 0);

    // 200 pairs with random consumer stalls against a scoreboard.
    do_reset();
    sent = 0; cycles = 0; stalled = 1'b0;
    held_num = '0; held_idx = '0;
    while ((sent < 200 || sb.size() != 0 || out_valid) && cycles < 5000) begin
      if (stalled) begin
        chk("t6_stall_valid", out_valid, 1);
        chk("t6_stall_num", out_num, held_num);
        chk("t6_stall_idx", out_idx, held_idx);
      end
      up_valid  = (sent < 200);
      up_num    = 16'(2 * sent);
      up_num2   = 16'(2 * sent + 1);
      out_ready = 1'($urandom_range(0, 1));
      if (up_valid && up_ready) begin
        sb.push_back(up_num);
        sb.push_back(up_num2);
        sent++;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("t6_unexpected_term", out_num, 16'hffff);
        end else begin
          exp_v = sb.pop_front();
          chk("t6_num", out_num, exp_v);
          chk("t6_idx", out_idx, exp_idx);
          exp_idx++;
        end
      end
      stalled  = out_valid && !out_ready;
      held_num = out_num;
      held_idx = out_idx;
      tick();
      cycles++;
    end
    chk("t6_all_sent", sent, 200);
    chk("t6_all_emitted", sb.size(), 0);
    chk("t6_final_idx", out_idx, 400);
    chk("t6_wrap", wrap_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
